// File: rtl/i2f_seq_if.sv
// Handshake bundle for the sequential int32 -> float32 converter.
// The master drives start/a. The slave returns the result and status.
interface i2f_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] d;
    logic        p_lost;
    logic        busy;
    logic        done;

    modport master (output start, a, input d, p_lost, busy, done);
    modport slave  (input start, a, output d, p_lost, busy, done);
endinterface

// File: rtl/i2f_seq.sv
// Multi-cycle signed int32 -> IEEE-754 single converter using round-to-nearest-even.
// The operand is normalised one bit per cycle, then rounded in a single cycle.
module i2f_seq (
    input  logic       clk,
    input  logic       clrn,
    i2f_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp;

    logic [31:0] a_mag;
    logic [22:0] frac;
    logic        guard, sticky, rnd_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_rnd;

    // The magnitude of 0x80000000 wraps to itself, which is the correct unsigned value.
    assign a_mag = bus.a[31] ? (~bus.a + 32'd1) : bus.a;

    always_comb begin
        frac     = mag[30:8];
        guard    = mag[7];
        sticky   = |mag[6:0];
        rnd_up   = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {23'd0, rnd_up};
        // On a carry out of the fraction, frac_sum[22:0] is already zero.
        exp_rnd  = exp + {7'd0, frac_sum[23]};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            sign       <= 1'b0;
            mag        <= '0;
            exp        <= '0;
            bus.d      <= '0;
            bus.p_lost <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                    if (bus.start) begin
                        if (bus.a == 32'd0) begin
                            bus.d      <= '0;
                            bus.p_lost <= 1'b0;
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            sign     <= bus.a[31];
                            mag      <= a_mag;
                            exp      <= 8'd158;
                            bus.busy <= 1'b1;
                            state    <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= mag << 1;
                        exp <= exp - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    bus.d      <= {sign, exp_rnd, frac_sum[22:0]};
                    bus.p_lost <= |mag[7:0];
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2f_seq.sv
// Randomised and directed scoreboard bench for i2f_seq.
// The reference model computes the float with plain integer arithmetic.
module tb_i2f_seq;
    logic clk = 1'b0;
    logic clrn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    i2f_seq_if bus ();
    i2f_seq dut (.clk(clk), .clrn(clrn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        p;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] last_d;
    logic        last_p;

    // Reference result: {d, inexact}; s_out is the leading-zero count of |x|.
    function automatic logic [32:0] ref_conv(input logic [31:0] x, output int s_out);
        longint unsigned m, q, rem, half;
        int p, sh;
        logic [7:0] e;
        s_out = 0;
        if (x == 32'd0) return 33'd0;
        m = {32'd0, x};
        if (x[31]) m = 64'h1_0000_0000 - m;
        p = 0;
        for (int i = 0; i < 33; i++) if (((m >> i) & 1) != 0) p = i;
        s_out = 31 - p;
        rem = 0;
        if (p <= 23) q = m << (23 - p);
        else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin q = q >> 1; p = p + 1; end
        end
        e = 8'(p + 127);
        return {x[31], e, q[22:0], rem != 0};
    endfunction

    // Monitor: pops on every done pulse; otherwise the result must be held.
    always @(negedge clk) begin
        exp_t ex;
        if (!clrn) begin
            last_d = '0;
            last_p = 1'b0;
        end else if (bus.done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: d=%h p_lost=%b cyc=%0d, required no done", bus.d, bus.p_lost, cyc);
            end else begin
                ex = sb.pop_front();
                if (bus.d !== ex.d || bus.p_lost !== ex.p || cyc != ex.cyc) begin
                    n_err++;
                    $display("FAIL result a=%h: got d=%h p=%b cyc=%0d, required d=%h p=%b cyc=%0d",
                             ex.a, bus.d, bus.p_lost, cyc, ex.d, ex.p, ex.cyc);
                end
            end
            last_d = bus.d;
            last_p = bus.p_lost;
        end else begin
            n_cmp++;
            if (bus.d !== last_d || bus.p_lost !== last_p) begin
                n_err++;
                $display("FAIL hold: got d=%h p=%b, required d=%h p=%b", bus.d, bus.p_lost, last_d, last_p);
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        n_cmp++;
        if (bus.d !== 32'd0 || bus.p_lost !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got d=%h p=%b busy=%b done=%b, required all zero",
                     tag, bus.d, bus.p_lost, bus.busy, bus.done);
        end
    endtask

    // Issue one conversion. If use_tab is set, the expected value comes from the table.
    task automatic issue(input logic [31:0] x, input bit use_tab, input logic [31:0] td, input logic tp);
        exp_t ex;
        int   s, to;
        logic [32:0] r;
        @(negedge clk);
        to = 0;
        while (bus.busy && to < 500) begin @(negedge clk); to++; end
        if (to >= 500) begin
            n_cmp++; n_err++;
            $display("FAIL busy_timeout: busy=%b, required 0", bus.busy);
        end
        bus.start = 1'b1;
        bus.a     = x;
        @(posedge clk);
        #1;
        r      = ref_conv(x, s);
        ex.a   = x;
        ex.d   = use_tab ? td : r[32:1];
        ex.p   = use_tab ? tp : r[0];
        ex.cyc = (x == 32'd0) ? cyc : cyc + s + 2;
        sb.push_back(ex);
        bus.start = 1'b0;
        bus.a     = $urandom;
    endtask

    typedef struct { logic [31:0] a; logic [31:0] d; logic p; } dir_t;
    dir_t dir[8];

    initial begin
        int to;
        logic [31:0] x;
        dir[0] = '{32'h0000_0001, 32'h3F80_0000, 1'b0};
        dir[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
        dir[2] = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
        dir[3] = '{32'h8000_0000, 32'hCF00_0000, 1'b0};
        dir[4] = '{32'h0100_0001, 32'h4B80_0000, 1'b1};
        dir[5] = '{32'h0100_0003, 32'h4B80_0002, 1'b1};
        dir[6] = '{32'h0000_0003, 32'h4040_0000, 1'b0};
        dir[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0};

        clrn = 1'b0; bus.start = 1'b0; bus.a = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset_state");
        @(negedge clk) clrn = 1'b1;

        // Consecutive issues land in DONE whenever the previous op was nonzero.
        foreach (dir[i]) issue(dir[i].a, 1'b1, dir[i].d, dir[i].p);

        // A start pulsed during busy must be ignored.
        issue(32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1);
        repeat (5) begin
            @(negedge clk);
            if (bus.busy) begin bus.start = 1'b1; bus.a = $urandom | 32'h1; end
            @(posedge clk);
            #1 bus.start = 1'b0;
        end

        // Reset during NORM: everything clears and no done appears.
        issue(32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0);
        repeat (5) @(posedge clk);
        #3 clrn = 1'b0;
        #1 check_reset_outs("reset_mid_norm");
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #3 clrn = 1'b1;
        repeat (40) @(posedge clk);
        issue(32'h0000_0003, 1'b1, 32'h4040_0000, 1'b0);

        for (int i = 0; i < 200; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 15) == 0) x = 32'd0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            issue(x, 1'b0, 32'd0, 1'b0);
        end

        to = 0;
        while (sb.size() > 0 && to < 200) begin @(negedge clk); to++; end
        if (sb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
